// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: control, divisor-config and timing-strobe bundle of uart_baud_gen
// master = UART control FSM side, slave = the bit-timing generator.
interface uart_baud_gen_if #(
    parameter int CNT_W = 16,
    parameter int FRAC_W = 4,
    parameter int FRAME_BITS = 10
);
    localparam int BI_W = $clog2(FRAME_BITS);
    logic En, Abort, Div_Wr;
    logic [CNT_W-1:0] Div_Int_In;
    logic [FRAC_W-1:0] Div_Frac_In;
    logic Busy, Mid_Tick, Bit_Tick, Frame_Done, Cfg_Err;
    logic [BI_W-1:0] Bit_Idx;
    modport master (
        output En, Abort, Div_Wr, Div_Int_In, Div_Frac_In,
        input Busy, Mid_Tick, Bit_Tick, Bit_Idx, Frame_Done, Cfg_Err
    );
    modport slave (
        input En, Abort, Div_Wr, Div_Int_In, Div_Frac_In,
        output Busy, Mid_Tick, Bit_Tick, Bit_Idx, Frame_Done, Cfg_Err
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional-divisor UART bit-timing generator with mid/end-of-bit strobes
// Bit periods dither between Div_Int and Div_Int+1 so the average is Div_Int + Div_Frac/2^FRAC_W.
module uart_baud_gen #(
    parameter int CNT_W = 16,
    parameter int FRAC_W = 4,
    parameter int FRAME_BITS = 10,
    parameter int RESET_DIV_INT = 52,
    parameter int RESET_DIV_FRAC = 0
) (
    input logic CLK,
    input logic RSTn,
    uart_baud_gen_if.slave bus
);
    localparam int BI_W = $clog2(FRAME_BITS);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN = 1'b1;
    localparam logic [BI_W-1:0] LAST = BI_W'(FRAME_BITS - 1);
    localparam logic [BI_W-1:0] IDX_ONE = BI_W'(1);
    localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);
    logic [0:0] state;
    logic [CNT_W-1:0] div_int, dint;
    logic [FRAC_W-1:0] div_frac, dfrac, acc;
    logic [FRAC_W:0] sum;
    logic [CNT_W:0] cnt, per, per_nx;
    logic [BI_W-1:0] bit_idx;
    logic run, wr_ok, start, tick, last, cfg_err;
    assign run = state == RUN;
    assign wr_ok = bus.Div_Wr && !run && bus.Div_Int_In >= CNT_W'(2);
    // A write accepted in the start cycle must already shape the first bit.
    assign dint = wr_ok ? bus.Div_Int_In : div_int;
    assign dfrac = wr_ok ? bus.Div_Frac_In : div_frac;
    assign sum = {1'b0, acc} + {1'b0, dfrac};
    assign per_nx = {1'b0, dint} + {{CNT_W{1'b0}}, sum[FRAC_W]};
    assign start = !run && bus.En && !bus.Abort;
    assign tick = run && !bus.Abort && cnt == per - ONE;
    assign last = bit_idx == LAST;
    assign bus.Busy = run;
    assign bus.Mid_Tick = run && !bus.Abort && cnt == (per >> 1);
    assign bus.Bit_Tick = tick;
    assign bus.Frame_Done = tick && last;
    assign bus.Bit_Idx = bit_idx;
    assign bus.Cfg_Err = cfg_err;
    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) begin
            state <= IDLE;
            cnt <= '0;
            per <= '0;
            acc <= '0;
            bit_idx <= '0;
            cfg_err <= 1'b0;
            div_int <= CNT_W'(RESET_DIV_INT);
            div_frac <= FRAC_W'(RESET_DIV_FRAC);
        end else begin
            cfg_err <= bus.Div_Wr && !wr_ok;
            if (wr_ok) begin
                div_int <= bus.Div_Int_In;
                div_frac <= bus.Div_Frac_In;
            end
            if (bus.Abort) begin
                state <= IDLE;
                cnt <= '0;
                acc <= '0;
                bit_idx <= '0;
            end else if (start || (tick && (!last || bus.En))) begin
                // New bit: latch its period and keep the fractional phase running across frames.
                state <= RUN;
                cnt <= '0;
                per <= per_nx;
                acc <= sum[FRAC_W-1:0];
                bit_idx <= (start || last) ? '0 : bit_idx + IDX_ONE;
            end else if (tick) begin
                state <= IDLE;
                cnt <= '0;
                acc <= '0;
                bit_idx <= '0;
            end else if (run) begin
                cnt <= cnt + ONE;
            end
        end
endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised UART bit-timing generator that replaces the fixed 52-cycle bit counter. It has a runtime-programmable divisor with a fractional part, mid-bit and end-of-bit strobes, and a bit index within a frame. It also provides frame-completion, back-to-back frames and abort. It sits between the UART control FSMs (TX and RX instances) and the shift registers, and is driven by the transmit/receive enable.

## Interface
- CNT_W, 16: width of the integer divisor; the internal period counter is CNT_W+1 bits.
- FRAC_W, 4: width of the fractional divisor; the divisor equals Div_Int + Div_Frac/2^FRAC_W.
- FRAME_BITS, 10: bits per frame (start + 8 data + stop); must be at least 2.
- RESET_DIV_INT, 52: integer divisor loaded at reset (500 kHz / 9600).
- RESET_DIV_FRAC, 0: fractional divisor loaded at reset.
- BI_W, derived localparam = clog2(FRAME_BITS).
- CLK  in  1  system clock; all logic is on the rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- En  in  1  start/continue request, level-sensitive.
- Abort  in  1  synchronous abort.
- Div_Wr  in  1  divisor write strobe.
- Div_Int_In  in  CNT_W  new integer divisor.
- Div_Frac_In  in  FRAC_W  new fractional divisor.
- Busy  out  1  high while in the RUN state.
- Mid_Tick  out  1  one-cycle pulse at mid-bit, used as the RX sample point.
- Bit_Tick  out  1  one-cycle pulse on the last cycle of each bit.
- Bit_Idx  out  BI_W  index of the current bit, 0..FRAME_BITS-1.
- Frame_Done  out  1  one-cycle pulse, coincident with Bit_Tick of the last bit.
- Cfg_Err  out  1  one-cycle pulse when a divisor write is rejected.

## Operation
- Reset values:
  - state = IDLE; cnt = 0; acc = 0; Bit_Idx = 0.
  - Divisor = RESET_DIV_INT / RESET_DIV_FRAC.
  - Busy, Mid_Tick, Bit_Tick, Frame_Done and Cfg_Err are all 0.
- Divisor write:
  - Div_Wr is accepted only when Busy = 0 and Div_Int_In ≥ 2.
  - Otherwise the divisor is unchanged and Cfg_Err pulses on the next cycle.
- Period length per bit: P = div_int + c.
  - At each bit start, {c, acc} <= acc + div_frac (an FRAC_W+1-bit sum).
  - P is latched for the whole bit, in CNT_W+1 bits with no overflow.
- IDLE state:
  - cnt, acc and Bit_Idx are held at 0.
  - En = 1 and Abort = 0 moves to RUN, with cnt = 0 and Bit_Idx = 0, and computes the first period.
  - If Div_Wr is accepted in the same cycle as the start, the first bit already uses the new divisor.
- RUN state: cnt increments every cycle.
  - Mid_Tick is decoded when cnt == P>>1.
  - Bit_Tick is decoded when cnt == P-1. On that cycle cnt wraps to 0, the next period is latched and Bit_Idx increments.
- Last bit (Bit_Idx == FRAME_BITS-1) with Bit_Tick:
  - Frame_Done = 1.
  - If En = 1, the next frame starts back-to-back: Bit_Idx = 0 and acc is kept, so there is no gap cycle.
  - If En = 0, the block returns to IDLE and acc is cleared.
- En deasserted mid-frame: the current frame completes. This is not an abort.
- Abort = 1 in any state: the next state is IDLE with all counters cleared.
  - Mid_Tick, Bit_Tick and Frame_Done are gated to 0 in the Abort cycle.
  - Abort wins over En and over a simultaneous Bit_Tick.
- Bit_Idx is a held register; it never exceeds FRAME_BITS-1.

## Timing
- Start latency: En sampled high at edge 0 gives Busy = 1 and cnt = 0 from edge 1.
- The first Mid_Tick occurs P>>1 cycles after Busy rises; the first Bit_Tick occurs P-1 cycles after Busy rises.
- Ticks are combinational decodes of registered state, so they are glitch-free relative to CLK and exactly 1 cycle wide.
- Default divisor (52.0): Mid_Tick at cnt = 26, Bit_Tick at cnt = 51, and a frame is 520 cycles.
- Busy drops on the edge after Frame_Done when En = 0.
- Divisor changes never take effect mid-frame, because writes are rejected while Busy.
- Minimum period P = 2: Mid_Tick is at cnt = 1, coincident with Bit_Tick. Both are asserted in that cycle.

## Test plan
- Reset, then pulse En for 1 cycle with the default divisor:
  - Mid_Tick at cycles 1+26+52k, Bit_Tick at cycles 52+52k for k = 0..9.
  - Frame_Done at cycle 520, Busy low from cycle 521.
  - Bit_Idx steps 0..9.
- Write 52 + 8/16 while idle, then run one frame:
  - Bit periods alternate 52, 53, 52, 53, …
  - The frame totals 525 cycles.
  - Mid_Tick at cnt 26 for every bit (both 52>>1 and 53>>1).
- Hold En high for 3 frames:
  - Frame_Done pulses at 520, 1040 and 1560 with no idle gap.
  - Bit_Idx wraps 9 → 0 on the Bit_Tick cycle.
- Div_Wr while Busy, and Div_Wr with Div_Int_In = 1:
  - Cfg_Err pulses for one cycle.
  - The divisor is unchanged; the frame still takes 520 cycles.
- Assert Abort at Bit_Idx 4 on the Bit_Tick cycle:
  - No Bit_Tick or Frame_Done in that cycle.
  - Next cycle: Busy = 0, Bit_Idx = 0.
  - A restart with En gives a full 520-cycle frame.
- Assert RSTn low mid-frame, then release:
  - All outputs are 0 immediately.
  - The divisor returns to 52.0.
  - No ticks occur until En is asserted.
